// File: rtl/sdmac_pkg.sv
// Shared constants for the SCSI DMA control/status register stage.
// Latency: n/a (constants, types and a combinational ISTR packer only).
// Backpressure: n/a.
// Contents: CNTR/ISTR bit indices, flush FSM state encoding, ISTR pack helper.
package sdmac_pkg;

  // CNTR bits that drive outputs; the remaining bits are plain storage.
  localparam int CNTR_INTEN  = 1;
  localparam int CNTR_DMADIR = 2;

  // ISTR layout; unlisted bits read as zero.
  localparam int ISTR_INT_F  = 8;
  localparam int ISTR_FE_FLG = 6;
  localparam int ISTR_E_INT  = 5;
  localparam int ISTR_INTS   = 4;
  localparam int ISTR_FULL   = 1;
  localparam int ISTR_EMPTY  = 0;

  typedef enum logic [1:0] {
    FL_IDLE = 2'd0,
    FL_REQ  = 2'd1,
    FL_DONE = 2'd2
  } flush_state_e;

  function automatic logic [8:0] pack_istr(input logic ints, input logic e_int,
                                           input logic fe_flg, input logic full,
                                           input logic empty);
    logic [8:0] v;
    v              = '0;
    v[ISTR_INT_F]  = ints | e_int;
    v[ISTR_FE_FLG] = fe_flg;
    v[ISTR_E_INT]  = e_int;
    v[ISTR_INTS]   = ints;
    v[ISTR_FULL]   = full;
    v[ISTR_EMPTY]  = empty;
    return v;
  endfunction

endpackage

// File: rtl/sdmac_ctrl_regs_if.sv
// CPU-side bus between the address decoder (master) and the register stage (slave).
// Latency: n/a (wires only).
// Backpressure: none; strobes are levels held for the whole CPU bus cycle.
// Signals: din, write/read/action strobes (_n = active low), dout/doe read return, dmadir.
interface sdmac_ctrl_regs_if;
  logic [8:0] din;
  logic       contr_wr;
  logic       contr_rd_n;
  logic       istr_rd_n;
  logic       st_dma;
  logic       sp_dma;
  logic       clr_int;
  logic       flush_n;
  logic [8:0] dout;
  logic       doe;
  logic       dmadir;

  modport master (
    output din, contr_wr, contr_rd_n, istr_rd_n, st_dma, sp_dma, clr_int, flush_n,
    input  dout, doe, dmadir
  );

  modport slave (
    input  din, contr_wr, contr_rd_n, istr_rd_n, st_dma, sp_dma, clr_int, flush_n,
    output dout, doe, dmadir
  );
endinterface

// File: rtl/sdmac_ctrl_regs_strobe_edge.sv
// Registered leading-edge detector for one level strobe, polarity selectable.
// Latency: fire_o is combinational from strobe_i against last cycle's copy.
// Backpressure: none. Ports: clk_i, rst_ni (sync, active low), strobe_i, fire_o.
module sdmac_ctrl_regs_strobe_edge #(
  parameter bit ACT_LOW = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_i,
  output logic fire_o
);

  logic active;
  logic prev_q;

  // Normalise to active-high so prev_q resets to "inactive" for both polarities.
  assign active = strobe_i ^ ACT_LOW;
  assign fire_o = active & ~prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= active;
  end

endmodule

// File: rtl/sdmac_ctrl_regs.sv
// SCSI DMA control/status registers: CNTR, DMAENA, ISTR latches, INT_, flush handshake.
// Latency: strobe in cycle N acts at edge N+1; INT_ follows ISTR one cycle later (N+2).
// Backpressure: none; one action per strobe assertion however long it is held.
// Ports: sclk_i, rst_ni, bus (slave), inta_i, dma_end_i, fifo_empty_i, fifo_full_i,
//        flush_done_i, inten_o, dmaena_o, flush_req_o, int_n_o.
module sdmac_ctrl_regs
  import sdmac_pkg::*;
(
  input  logic                 sclk_i,
  input  logic                 rst_ni,
  sdmac_ctrl_regs_if.slave     bus,
  input  logic                 inta_i,
  input  logic                 dma_end_i,
  input  logic                 fifo_empty_i,
  input  logic                 fifo_full_i,
  input  logic                 flush_done_i,
  output logic                 inten_o,
  output logic                 dmaena_o,
  output logic                 flush_req_o,
  output logic                 int_n_o
);

  logic wr_fire, rdc_fire, rdi_fire, st_fire, sp_fire, clr_fire, fl_fire, inta_fire;

  sdmac_ctrl_regs_strobe_edge #(.ACT_LOW(1'b0)) u_wr   (.clk_i(sclk_i), .rst_ni(rst_ni), .strobe_i(bus.contr_wr),   .fire_o(wr_fire));
  sdmac_ctrl_regs_strobe_edge #(.ACT_LOW(1'b1)) u_rdc  (.clk_i(sclk_i), .rst_ni(rst_ni), .strobe_i(bus.contr_rd_n), .fire_o(rdc_fire));
  sdmac_ctrl_regs_strobe_edge #(.ACT_LOW(1'b1)) u_rdi  (.clk_i(sclk_i), .rst_ni(rst_ni), .strobe_i(bus.istr_rd_n),  .fire_o(rdi_fire));
  sdmac_ctrl_regs_strobe_edge #(.ACT_LOW(1'b0)) u_st   (.clk_i(sclk_i), .rst_ni(rst_ni), .strobe_i(bus.st_dma),     .fire_o(st_fire));
  sdmac_ctrl_regs_strobe_edge #(.ACT_LOW(1'b0)) u_sp   (.clk_i(sclk_i), .rst_ni(rst_ni), .strobe_i(bus.sp_dma),     .fire_o(sp_fire));
  sdmac_ctrl_regs_strobe_edge #(.ACT_LOW(1'b0)) u_clr  (.clk_i(sclk_i), .rst_ni(rst_ni), .strobe_i(bus.clr_int),    .fire_o(clr_fire));
  sdmac_ctrl_regs_strobe_edge #(.ACT_LOW(1'b1)) u_fl   (.clk_i(sclk_i), .rst_ni(rst_ni), .strobe_i(bus.flush_n),    .fire_o(fl_fire));
  sdmac_ctrl_regs_strobe_edge #(.ACT_LOW(1'b0)) u_inta (.clk_i(sclk_i), .rst_ni(rst_ni), .strobe_i(inta_i),         .fire_o(inta_fire));

  logic [8:0]   cntr_q, cntr_d;
  logic [8:0]   dout_q, dout_d;
  logic         dmaena_q, dmaena_d;
  logic         ints_q, ints_d;
  logic         e_int_q, e_int_d;
  logic         fe_flg_q, fe_flg_d;
  logic         int_n_q, int_n_d;
  logic         doe_q, doe_d;
  logic [8:0]   istr;
  logic         fe_set;
  flush_state_e state_q, state_d;

  assign istr = pack_istr(ints_q, e_int_q, fe_flg_q, fifo_full_i, fifo_empty_i);

  // Register next-state. Set events take priority over CLR_INT; ST_DMA beats
  // SP_DMA and DMA_END for DMAENA.
  always_comb begin
    cntr_d   = cntr_q;
    dmaena_d = dmaena_q;
    ints_d   = ints_q;
    e_int_d  = e_int_q;
    fe_flg_d = fe_flg_q;
    dout_d   = dout_q;

    if (wr_fire) cntr_d = bus.din;

    if (st_fire)                     dmaena_d = 1'b1;
    else if (sp_fire || dma_end_i)   dmaena_d = 1'b0;

    if (inta_fire)     ints_d = 1'b1;
    else if (clr_fire) ints_d = 1'b0;

    if (dma_end_i)     e_int_d = 1'b1;
    else if (clr_fire) e_int_d = 1'b0;

    if (fe_set)        fe_flg_d = 1'b1;
    else if (clr_fire) fe_flg_d = 1'b0;

    // Snapshot on the read edge; held for the rest of the bus cycle.
    if (rdc_fire)      dout_d = cntr_q;
    else if (rdi_fire) dout_d = istr;

    doe_d   = ~bus.contr_rd_n | ~bus.istr_rd_n;
    int_n_d = ~(cntr_q[CNTR_INTEN] & istr[ISTR_INT_F]);
  end

  always_ff @(posedge sclk_i) begin
    if (!rst_ni) begin
      cntr_q   <= '0;
      dmaena_q <= 1'b0;
      ints_q   <= 1'b0;
      e_int_q  <= 1'b0;
      fe_flg_q <= 1'b0;
      dout_q   <= '0;
      doe_q    <= 1'b0;
      int_n_q  <= 1'b1;
    end else begin
      cntr_q   <= cntr_d;
      dmaena_q <= dmaena_d;
      ints_q   <= ints_d;
      e_int_q  <= e_int_d;
      fe_flg_q <= fe_flg_d;
      dout_q   <= dout_d;
      doe_q    <= doe_d;
      int_n_q  <= int_n_d;
    end
  end

  // Flush FSM: state register.
  always_ff @(posedge sclk_i) begin
    if (!rst_ni) state_q <= FL_IDLE;
    else         state_q <= state_d;
  end

  // Flush FSM: next state. SP_DMA aborts a pending request without flagging FE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FL_IDLE: if (fl_fire && dmaena_q) state_d = FL_REQ;
      FL_REQ: begin
        if (sp_fire)           state_d = FL_IDLE;
        else if (flush_done_i) state_d = FL_DONE;
      end
      FL_DONE: if (!flush_done_i) state_d = FL_IDLE;
      default: state_d = FL_IDLE;
    endcase
  end

  // Flush FSM: outputs.
  always_comb begin
    flush_req_o = (state_q == FL_REQ);
    fe_set      = (state_q == FL_REQ) && flush_done_i && !sp_fire;
  end

  assign bus.dout   = dout_q;
  assign bus.doe    = doe_q;
  assign bus.dmadir = cntr_q[CNTR_DMADIR];
  assign inten_o    = cntr_q[CNTR_INTEN];
  assign dmaena_o   = dmaena_q;
  assign int_n_o    = int_n_q;

endmodule
